// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 sizes, FSM states,
// the captured-request record and request-legality helpers.
package dmem_pkg;

   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   localparam logic [31:0] MMIO_ADDR_DEF = 32'h0000_1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   // Request fields kept past the accept edge (word index is held separately
   // because its width depends on DEPTH_WORDS).
   typedef struct packed {
      logic        write;
      logic        mmio;
      logic [1:0]  off;
      logic [2:0]  size;
      logic [31:0] wdata;
   } req_q_t;

   // Unsigned sizes only exist for loads.
   function automatic logic bad_size(input logic [2:0] sz, input logic wr);
      case (sz)
         SZ_B, SZ_H, SZ_W: return 1'b0;
         SZ_BU, SZ_HU:     return wr;
         default:          return 1'b1;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] off);
      case (sz)
         SZ_H, SZ_HU: return off[0];
         SZ_W:        return off != 2'b00;
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
// Purely combinational; the top registers everything around it.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  off,
   input  logic [31:0] rword,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   logic [NUM_LANES-1:0][VEC_W-1:0] rd_l, old_l, wrep, new_l;
   logic [NUM_LANES-1:0]            be;
   logic [7:0]                      b;
   logic [15:0]                     h;

   assign rd_l   = rword;
   assign old_l  = old_word;
   assign merged = new_l;

   // Store data is replicated across lanes so the byte enables alone pick it.
   always_comb begin
      be   = '1;
      wrep = wdata;
      case (size)
         SZ_B, SZ_BU: begin
            be   = NUM_LANES'(1) << off;
            wrep = {4{wdata[7:0]}};
         end
         SZ_H, SZ_HU: begin
            be   = off[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign new_l[g] = be[g] ? wrep[g] : old_l[g];
   end

   always_comb begin
      b = rd_l[off];
      h = off[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_B:    rdata = {{24{b[7]}}, b};
         SZ_BU:   rdata = {24'b0, b};
         SZ_H:    rdata = {{16{h[15]}}, h};
         SZ_HU:   rdata = {16'b0, h};
         default: rdata = rword;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder for the RV32I data port: one request at a
// time, sub-word stores as read-modify-write, plus one LED MMIO register.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_size,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [5:0]  mmio_out
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ARR_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   state_t        state;
   req_q_t        q;
   logic [AW-1:0] q_idx;
   logic [31:0]   old_q;
   logic [31:0]   mem [DEPTH_WORDS];

   logic          in_mmio, in_arr, in_err;
   logic [31:0]   rd_word, ld_data, st_word;

   // Legality is decided from the live inputs so an error can respond at t+1.
   assign in_mmio = req_addr == MMIO_ADDR;
   assign in_arr  = {1'b0, req_addr} < ARR_BYTES;
   assign in_err  = bad_size(req_size, req_write)
                  || misaligned(req_size, req_addr[1:0])
                  || (!in_arr && !in_mmio)
                  || (in_mmio && req_size != SZ_W);

   assign rd_word = q.mmio ? {26'b0, mmio_out} : mem[q_idx];

   dmem_lane_unit u_lane (
      .size     (q.size),
      .off      (q.off),
      .rword    (rd_word),
      .old_word (old_q),
      .wdata    (q.wdata),
      .rdata    (ld_data),
      .merged   (st_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         q          <= '0;
         q_idx      <= '0;
         old_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mmio_out   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               q         <= '{write: req_write, mmio: in_mmio, off: req_addr[1:0],
                              size: req_size, wdata: req_wdata};
               q_idx     <= req_addr[AW+1:2];
               req_ready <= 1'b0;
               if (in_err) begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (req_write && req_size == SZ_W) begin
                  state <= ST_WRITE;
               end else begin
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               old_q <= rd_word;
               if (q.write) begin
                  state <= ST_WRITE;
               end else begin
                  state      <= ST_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= ld_data;
               end
            end
            ST_WRITE: begin
               if (q.mmio) mmio_out <= q.wdata[5:0];
               state      <= ST_RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Storage is not reset; the async reset forces IDLE, so an abandoned
   // transaction can never reach this enable.
   always_ff @(posedge clk) begin
      if (state == ST_WRITE && !q.mmio && !reset) mem[q_idx] <= st_word;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a byte-level reference model.
module tb_dmem_responder;

   localparam logic [31:0] MMIO = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_size = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [5:0]  mmio_out;

   int n_chk = 0;
   int n_fail = 0;

   bit [31:0] mm [256];
   bit [5:0]  m_mmio = '0;
   bit [31:0] last_rd;

   dmem_responder #(.DEPTH_WORDS(256), .MMIO_ADDR(MMIO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_size(req_size), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mmio_out(mmio_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: byte-granular view of memory, results from the size rules.
   task automatic model(input bit wr, input bit [31:0] a, input bit [31:0] wd,
                        input bit [2:0] sz, output bit e, output bit [31:0] rd,
                        output int lat);
      int nb, off;
      bit is_m;
      bit [31:0] w, mask;
      nb   = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
      off  = int'(a[1:0]);
      is_m = (a == MMIO);
      e    = (sz == 3'd3) || (sz >= 3'd6) || (wr && sz[2]) || ((off % nb) != 0)
           || (a >= 32'd1024 && !is_m) || (is_m && nb != 4);
      rd   = '0;
      if (e) begin
         lat = 1;
      end else if (!wr) begin
         lat  = 2;
         w    = is_m ? {26'b0, m_mmio} : mm[a[9:2]];
         mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
         rd   = (w >> (8 * off)) & mask;
         if (!sz[2] && nb < 4 && rd[8 * nb - 1]) rd = rd | ~mask;
      end else begin
         lat = (nb == 4) ? 2 : 3;
         if (is_m) begin
            m_mmio = wd[5:0];
         end else begin
            w = mm[a[9:2]];
            for (int i = 0; i < nb; i++) w[8 * (off + i) +: 8] = wd[8 * i +: 8];
            mm[a[9:2]] = w;
         end
      end
   endtask

   // Entered and left at a negedge with the DUT idle.
   task automatic do_req(input bit wr, input bit [31:0] a, input bit [31:0] wd,
                         input bit [2:0] sz, input string tag);
      bit e;
      bit [31:0] rd;
      int lat, n;
      model(wr, a, wd, sz, e, rd, lat);
      chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_size = sz;
      @(posedge clk); #1;
      req_valid = 1'($urandom); req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 10);
      last_rd = resp_rdata;
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, e});
      chk({tag, "_rdata"}, resp_rdata, rd);
      chk({tag, "_mmio"}, {26'b0, mmio_out}, {26'b0, m_mmio});
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
      chk({tag, "_vld"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, "_rd"}, resp_rdata, 32'd0);
      chk({tag, "_er"}, {31'b0, resp_err}, 32'd0);
      chk({tag, "_mmio"}, {26'b0, mmio_out}, 32'd0);
   endtask

   // Reset lands while an SB is in READ (extra=0) or WRITE (extra=1).
   task automatic reset_mid(input bit [31:0] a, input int extra, input string tag);
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = 32'h5A; req_size = 3'd0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (extra > 0) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      m_mmio = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_reset_outs({tag, "_held"});
      end
      reset = 1'b0;
      @(negedge clk);
      chk_reset_outs({tag, "_rel"});
      do_req(1'b0, {a[31:2], 2'b00}, 32'h0, 3'd2, {tag, "_lw"});
   endtask

   initial begin
      bit [31:0] a;
      repeat (2) @(negedge clk);
      chk_reset_outs("rst");
      reset = 1'b0;
      @(negedge clk);
      chk_reset_outs("rst_rel");

      for (int i = 0; i < 256; i++) do_req(1'b1, i * 4, $urandom, 3'd2, "fill");

      do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, "sw");
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw");
      chk("lw_const", last_rd, 32'hDEAD_BEEF);

      do_req(1'b1, 32'h10, 32'h1122_3344, 3'd2, "sw2");
      do_req(1'b1, 32'h13, 32'h0000_0080, 3'd0, "sb");
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw_sb");
      chk("sb_word", last_rd, 32'h8022_3344);
      do_req(1'b0, 32'h13, 32'h0, 3'd0, "lb");
      chk("lb_const", last_rd, 32'hFFFF_FF80);
      do_req(1'b0, 32'h13, 32'h0, 3'd4, "lbu");
      chk("lbu_const", last_rd, 32'h0000_0080);

      do_req(1'b1, 32'h22, 32'h0000_ABCD, 3'd1, "sh");
      do_req(1'b0, 32'h22, 32'h0, 3'd1, "lh");
      chk("lh_const", last_rd, 32'hFFFF_ABCD);
      do_req(1'b0, 32'h22, 32'h0, 3'd5, "lhu");
      chk("lhu_const", last_rd, 32'h0000_ABCD);
      do_req(1'b0, 32'h20, 32'h0, 3'd2, "lw_sh");

      do_req(1'b0, 32'h11, 32'h0, 3'd2, "e_lw_mis");
      do_req(1'b1, 32'h01, 32'hFFFF, 3'd1, "e_sh_mis");
      do_req(1'b0, 32'h2000, 32'h0, 3'd2, "e_range");
      do_req(1'b1, 32'h10, 32'h0, 3'd3, "e_size");
      do_req(1'b1, 32'h10, 32'h0, 3'd4, "e_sbu");
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw_after_err");
      do_req(1'b0, 32'h00, 32'h0, 3'd2, "lw_after_err0");

      do_req(1'b1, MMIO, 32'h3F, 3'd2, "mmio_sw");
      chk("mmio_const", {26'b0, mmio_out}, 32'h3F);
      do_req(1'b0, MMIO, 32'h0, 3'd2, "mmio_lw");
      chk("mmio_lw_const", last_rd, 32'h3F);
      do_req(1'b1, MMIO, 32'h0, 3'd0, "mmio_sb");

      reset_mid(32'h13, 0, "rst_read");
      reset_mid(32'h31, 1, "rst_write");

      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            0:       a = MMIO;
            1:       a = 32'd1024 + $urandom_range(0, 8192);
            default: a = $urandom_range(0, 1023);
         endcase
         do_req(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services the load/store port of the RV32I core. It accepts one request at a time over a valid/ready handshake and decodes the funct3-style size field into byte, halfword or word accesses. Loads are sign- or zero-extended; sub-word stores are done as read-modify-write. Address decode also selects one memory-mapped output register that drives the board LEDs.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the storage array (power of two).
- MMIO_ADDR, 32'h0000_1000, byte address of the LED output register (word-aligned, outside the array range).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; one clock, reset async active-high (fixed).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the byte, half or word is taken from the low lanes.
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- resp_valid  out  1  one-cycle response pulse; there is no backpressure.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  request rejected; qualified by resp_valid.
- mmio_out  out  6  LED register.

## Operation
- A request is accepted on an edge where req_valid && req_ready. The responder captures addr, wdata, size and write at that edge.
- States: IDLE, READ, WRITE, RESP.
- From IDLE:
  - error → RESP.
  - load → READ.
  - word store → WRITE.
  - sub-word store → READ.
- READ:
  - Performs a synchronous array read of word addr[31:2].
  - For a store, the next state is WRITE. For a load, the next state is RESP.
- WRITE:
  - Writes the merged word, or for MMIO writes mmio_out <= wdata[5:0].
  - Next state is RESP.
- RESP: asserts resp_valid for exactly one cycle, then returns to IDLE.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - B and H sign-extend. BU and HU zero-extend. W passes through.
- Store merge: only the addressed byte or half lanes are replaced; the other lanes keep the value from READ.
- A MMIO word load returns {26'b0, mmio_out}.
- Error conditions. On any of these, there is no array or MMIO write and resp_err = 1:
  - misaligned: H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0;
  - illegal size: 011, 110, 111, or BU/HU on a store;
  - address outside [0, 4·DEPTH_WORDS) that is not MMIO_ADDR;
  - a sub-word access to MMIO_ADDR.

## Timing
- Accept edge = t. resp_valid is high in the cycle following:
  - error: t+1;
  - word store: t+2;
  - load (array or MMIO): t+2;
  - sub-word store: t+3.
- Array and MMIO writes commit on the edge that leaves WRITE.
- req_ready is low from t until resp_valid has fallen. The earliest next accept is the edge that ends the RESP cycle, where req_ready is high again in IDLE.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mmio_out 0. Array contents are not reset.
- Reset mid-operation: the transaction is abandoned. A write whose WRITE edge has not occurred is never performed, and no response is produced.
- req_valid outside IDLE is ignored. Request inputs need not be held after the accept edge.

## Structure
- Package dmem_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU);
  - the state enum;
  - the MMIO_ADDR default.
- Sub-module dmem_lane_unit is combinational and contains:
  - load extract/extend (size, addr[1:0], word → rdata);
  - store merge (size, addr[1:0], old word, wdata → new word).
- Top level holds the FSM, the captured request registers, the array and the MMIO register.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10: store response at t+2; load resp_rdata = 0xDEADBEEF at t+2, resp_err = 0.
- SB 0x80 @0x13 over 0x11223344, then LB/LBU @0x13: word becomes 0x80223344; LB = 0xFFFFFF80, LBU = 0x00000080; store response at t+3.
- SH 0xABCD @0x22, then LH/LHU @0x22: LH = 0xFFFFABCD, LHU = 0x0000ABCD; lower half unchanged.
- LW @0x11, SH @0x01, LW @0x2000, size 011: each gives resp_err = 1 at t+1 with no memory change; a following read confirms contents.
- SW 0x3F @MMIO_ADDR: mmio_out = 6'h3F after WRITE; LW @MMIO_ADDR returns 0x0000003F; SB @MMIO_ADDR errors.
- Assert reset during a pending SB (state READ): no response and the word is unchanged. After release, outputs are at reset values and the next LW is serviced normally.
